// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and sclk edge-role helper for spi_slave_sync
//  spi_state_e  : IDLE (no frame) / ACTIVE (cs_n asserted)
//  edge_roles_t : which synchronised sclk edge samples mosi and which shifts miso
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} spi_state_e;
  typedef struct packed {
    logic sample_rise;
    logic shift_rise;
  } edge_roles_t;
  // Leading edge is the one leaving CPOL; CPHA=0 samples on it, CPHA=1 on the trailing one.
  function automatic edge_roles_t edge_roles(input logic cpol, input logic cpha);
    edge_roles_t r;
    r.sample_rise = ~(cpol ^ cpha);
    r.shift_rise = cpol ^ cpha;
    return r;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with single-cycle rise/fall pulses
//  clk, rst_n : system clock, asynchronous active-low reset
//  i_d        : asynchronous input
//  o_q        : synchronised level
//  o_rise     : 1-cycle pulse when o_q goes 0->1
//  o_fall     : 1-cycle pulse when o_q goes 1->0
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end
  assign o_q = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI target running entirely in the clk domain, all four modes, multi-word frames
//  clk, rst_n         : system clock, asynchronous active-low reset
//  sclk, cs_n, mosi   : host SPI inputs (asynchronous, synchronised here)
//  miso, miso_oe      : serial data to host and its output enable (high while frame active)
//  tx_data, tx_valid  : next word to send; accepted into the shadow when tx_valid & tx_ready
//  tx_ready           : shadow buffer empty
//  rx_data, rx_valid  : last complete received word and its 1-cycle update pulse
//  tx_underrun        : 1-cycle pulse when a word starts with the shadow empty (zeros sent)
//  frame_active       : synchronised ~cs_n
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int   DATA_W      = 64,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_active
);
  localparam int CW = $clog2(DATA_W);
  localparam edge_roles_t ROLES = edge_roles(CPOL, CPHA);
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;
  spi_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_bit_cnt;
  logic [DATA_W-1:0] r_tx, r_shadow, r_rx_data;
  logic [DATA_W-2:0] r_rx_shift;
  logic [DATA_W-1:0] w_rx_next;
  logic r_shadow_full, r_miso, r_rx_valid, r_underrun;
  logic w_active, w_sclk_edge, w_sample, w_shift, w_sample_en, w_word_end, w_word_start, w_accept;
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_d(sclk), .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .i_d(cs_n), .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  // Same depth as sclk so the synchronised mosi lines up with the detected sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_active = r_state == ACTIVE;
    w_sclk_edge = w_sclk_rise | w_sclk_fall;
    w_sample = w_sclk_edge & (w_sclk_q == ROLES.sample_rise);
    w_shift = w_sclk_edge & (w_sclk_q == ROLES.shift_rise);
    w_sample_en = w_active & w_sample;
    w_word_end = w_sample_en & (r_bit_cnt == CW'(DATA_W - 1));
    // A cs_n rise on the final sample completes the word but starts no new one.
    w_word_start = (~w_active & w_cs_fall) | (w_word_end & ~w_cs_rise);
    w_accept = tx_valid & ~r_shadow_full;
    w_rx_next = {r_rx_shift, w_mosi};
    w_state_nxt = w_active ? (w_cs_rise ? IDLE : ACTIVE) : (w_cs_fall ? ACTIVE : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_tx <= '0;
      r_shadow <= '0;
      r_shadow_full <= 1'b0;
      r_rx_shift <= '0;
      r_rx_data <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso <= 1'b0;
    end else begin
      r_rx_valid <= w_word_end;
      r_underrun <= w_word_start & ~r_shadow_full;
      if (w_accept) r_shadow <= tx_data;
      // No bypass: an accept in a word-start cycle refills the shadow for the following word.
      r_shadow_full <= w_accept | (r_shadow_full & ~w_word_start);
      // In CPHA=0 the trailing edge right after a wrap belongs to the word already loaded.
      if (w_word_start) r_tx <= r_shadow_full ? r_shadow : '0;
      else if (w_active & w_shift & (CPHA || r_bit_cnt != '0)) r_tx <= r_tx << 1;
      if (w_active & w_shift & CPHA) r_miso <= r_tx[DATA_W-1];
      if (w_sample_en) begin
        r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + 1'b1;
        r_rx_shift <= w_rx_next[DATA_W-2:0];
        if (w_word_end) r_rx_data <= w_rx_next;
      end
      if (w_active & w_cs_rise) begin
        r_tx <= '0;
        r_miso <= 1'b0;
        r_bit_cnt <= '0;
        r_rx_shift <= '0;
      end
    end
  end
  assign miso_oe = w_active;
  assign miso = w_active & (CPHA ? r_miso : r_tx[DATA_W-1]);
  assign tx_ready = ~r_shadow_full;
  assign rx_data = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_active = ~w_cs_q;
endmodule
